// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the memory port arbiter (slave side) and its two requesters
// plus the single-port memory (master side).
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_gnt;
   logic              cpu_done;
   logic [DATA_W-1:0] cpu_rdata;

   logic              dbg_req;
   logic              dbg_we;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_wdata;
   logic              dbg_gnt;
   logic              dbg_done;
   logic [DATA_W-1:0] dbg_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              busy;
   logic              owner;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  mem_rdata,
      output cpu_gnt, cpu_done, cpu_rdata,
      output dbg_gnt, dbg_done, dbg_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output busy, owner
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output mem_rdata,
      input  cpu_gnt, cpu_done, cpu_rdata,
      input  dbg_gnt, dbg_done, dbg_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  busy, owner
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// CPU / debug arbiter and access sequencer for a single-port synchronous memory.
// Define MEM_ARB_RR_EN for round-robin; default is CPU priority with a starvation escape.
module mem_port_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MEM_LAT  = 1,
   parameter int MAX_WAIT = 8
) (
   input  logic              clk,
   input  logic              reset,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, GRANT, WAIT, RESP} state_t;

   state_t            state_reg;
   logic [2:0]        wait_cnt_reg;
   logic              cpu_gnt_reg;
   logic              dbg_gnt_reg;
   logic              cpu_done_reg;
   logic              dbg_done_reg;
   logic              mem_en_reg;
   logic              mem_we_reg;
   logic              we_reg;
   logic [ADDR_W-1:0] mem_addr_reg;
   logic [DATA_W-1:0] mem_wdata_reg;
   logic [DATA_W-1:0] cpu_rdata_reg;
   logic [DATA_W-1:0] dbg_rdata_reg;
   logic              busy_reg;
   logic              owner_reg;

   logic              any_req;
   logic              dbg_wins;
   logic              arb_fire;

   assign any_req  = bus.cpu_req | bus.dbg_req;
   assign arb_fire = (state_reg == IDLE) && any_req;

`ifdef MEM_ARB_RR_EN
   logic last_dbg_reg;

   // On a tie the port that did not win last time goes first.
   assign dbg_wins = bus.dbg_req && (!bus.cpu_req || !last_dbg_reg);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_dbg_reg <= 1'b1;
      end else if (arb_fire) begin
         last_dbg_reg <= dbg_wins;
      end
   end
`else
   logic [3:0] starve_reg;

   assign dbg_wins = bus.dbg_req && (!bus.cpu_req || (starve_reg == 4'(MAX_WAIT)));

   // Counts arbitrations the debug port lost while requesting.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_reg <= '0;
      end else if (arb_fire) begin
         if (dbg_wins) begin
            starve_reg <= '0;
         end else if (bus.dbg_req) begin
            starve_reg <= starve_reg + 4'd1;
         end
      end
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= IDLE;
         wait_cnt_reg  <= '0;
         cpu_gnt_reg   <= 1'b0;
         dbg_gnt_reg   <= 1'b0;
         cpu_done_reg  <= 1'b0;
         dbg_done_reg  <= 1'b0;
         mem_en_reg    <= 1'b0;
         mem_we_reg    <= 1'b0;
         we_reg        <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
         cpu_rdata_reg <= '0;
         dbg_rdata_reg <= '0;
         busy_reg      <= 1'b0;
         owner_reg     <= 1'b0;
      end else begin
         cpu_gnt_reg  <= 1'b0;
         dbg_gnt_reg  <= 1'b0;
         cpu_done_reg <= 1'b0;
         dbg_done_reg <= 1'b0;
         mem_en_reg   <= 1'b0;
         mem_we_reg   <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (any_req) begin
                  state_reg     <= GRANT;
                  busy_reg      <= 1'b1;
                  owner_reg     <= dbg_wins;
                  cpu_gnt_reg   <= !dbg_wins;
                  dbg_gnt_reg   <= dbg_wins;
                  mem_en_reg    <= 1'b1;
                  mem_we_reg    <= dbg_wins ? bus.dbg_we    : bus.cpu_we;
                  we_reg        <= dbg_wins ? bus.dbg_we    : bus.cpu_we;
                  mem_addr_reg  <= dbg_wins ? bus.dbg_addr  : bus.cpu_addr;
                  mem_wdata_reg <= dbg_wins ? bus.dbg_wdata : bus.cpu_wdata;
               end
            end
            GRANT: begin
               state_reg    <= WAIT;
               wait_cnt_reg <= 3'(MEM_LAT - 1);
            end
            WAIT: begin
               if (wait_cnt_reg == 3'd0) begin
                  state_reg    <= RESP;
                  cpu_done_reg <= !owner_reg;
                  dbg_done_reg <= owner_reg;
                  // Read data is valid in the final WAIT cycle only.
                  if (!we_reg) begin
                     if (owner_reg) begin
                        dbg_rdata_reg <= bus.mem_rdata;
                     end else begin
                        cpu_rdata_reg <= bus.mem_rdata;
                     end
                  end
               end else begin
                  wait_cnt_reg <= wait_cnt_reg - 3'd1;
               end
            end
            RESP: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cpu_gnt   = cpu_gnt_reg;
   assign bus.dbg_gnt   = dbg_gnt_reg;
   assign bus.cpu_done  = cpu_done_reg;
   assign bus.dbg_done  = dbg_done_reg;
   assign bus.cpu_rdata = cpu_rdata_reg;
   assign bus.dbg_rdata = dbg_rdata_reg;
   assign bus.mem_en    = mem_en_reg;
   assign bus.mem_we    = mem_we_reg;
   assign bus.mem_addr  = mem_addr_reg;
   assign bus.mem_wdata = mem_wdata_reg;
   assign bus.busy      = busy_reg;
   assign bus.owner     = owner_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected grants/completions,
// a negedge monitor pops and compares whenever the DUT pulses gnt or done.
module tb_mem_port_arbiter;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int LAT  = 3;
   localparam int MAXW = 8;

   typedef struct {
      logic        port;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          gnt_at;
   } txn_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .MAX_WAIT(MAXW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   txn_t        gnt_q[$];
   txn_t        done_q[$];
   int          compared   = 0;
   int          mismatched = 0;
   int          cyc        = 0;
   logic [31:0] shadow [2];
   int          gnt_cyc [2];

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: word array with a LAT-deep read pipeline; junk when no read is due.
   logic [31:0] mem [64];
   bit          wr  [64];
   bit   [LAT-1:0] pv;
   logic [31:0] pd [LAT];

   function automatic logic [31:0] mem_def(input logic [5:0] w);
      return (w == 6'h04) ? 32'hDEAD_BEEF : (32'h5500_0000 | {24'b0, w, 2'b00});
   endfunction

   always @(posedge clk) begin
      if (bus.mem_en && bus.mem_we) begin
         mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
         wr[bus.mem_addr[7:2]]  <= 1'b1;
      end
      pv[0] <= bus.mem_en && !bus.mem_we;
      pd[0] <= wr[bus.mem_addr[7:2]] ? mem[bus.mem_addr[7:2]] : mem_def(bus.mem_addr[7:2]);
      for (int i = 1; i < LAT; i++) begin
         pv[i] <= pv[i-1];
         pd[i] <= pd[i-1];
      end
   end
   assign bus.mem_rdata = pv[LAT-1] ? pd[LAT-1] : 32'hA5A5_A5A5;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      compared++;
      mismatched++;
      $display("FAIL %s_timeout: DUT event not seen in budget (cycle %0d)", name, cyc);
   endtask

   // Monitor
   always @(negedge clk) begin
      txn_t t;
      if (bus.cpu_gnt || bus.dbg_gnt) begin
         if (gnt_q.size() == 0) begin
            check("unexpected_gnt", {30'b0, bus.cpu_gnt, bus.dbg_gnt}, 32'd0);
         end else begin
            t = gnt_q.pop_front();
            check("gnt_port", {30'b0, bus.cpu_gnt, bus.dbg_gnt}, t.port ? 32'd1 : 32'd2);
            check("gnt_mem_en", 32'(bus.mem_en), 32'd1);
            check("gnt_mem_we", 32'(bus.mem_we), 32'(t.we));
            check("gnt_mem_addr", bus.mem_addr, t.addr);
            if (t.we) check("gnt_mem_wdata", bus.mem_wdata, t.wdata);
            check("gnt_owner", 32'(bus.owner), 32'(t.port));
            check("gnt_busy", 32'(bus.busy), 32'd1);
            if (t.gnt_at >= 0) check("gnt_cycle", 32'(cyc), 32'(t.gnt_at));
            gnt_cyc[int'(t.port)] = cyc;
            $display("grant  port=%0d we=%0b addr=0x%08h cycle=%0d", t.port, t.we, t.addr, cyc);
         end
      end else if (bus.mem_en) begin
         check("mem_en_without_gnt", 32'(bus.mem_en), 32'd0);
      end
      if (bus.cpu_done || bus.dbg_done) begin
         if (done_q.size() == 0) begin
            check("unexpected_done", {30'b0, bus.cpu_done, bus.dbg_done}, 32'd0);
         end else begin
            t = done_q.pop_front();
            check("done_port", {30'b0, bus.cpu_done, bus.dbg_done}, t.port ? 32'd1 : 32'd2);
            check("done_rdata", t.port ? bus.dbg_rdata : bus.cpu_rdata, t.rdata);
            check("done_latency", 32'(cyc - gnt_cyc[int'(t.port)]), 32'(LAT + 1));
            check("done_busy", 32'(bus.busy), 32'd1);
            $display("done   port=%0d we=%0b rdata=0x%08h cycle=%0d", t.port, t.we,
                     t.port ? bus.dbg_rdata : bus.cpu_rdata, cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rd, input int gnt_at);
      txn_t t;
      t.port = port; t.we = we; t.addr = addr; t.wdata = wdata; t.gnt_at = gnt_at;
      if (!we) shadow[int'(port)] = rd;
      t.rdata = shadow[int'(port)];
      gnt_q.push_back(t);
      done_q.push_back(t);
   endtask

   task automatic set_req(input logic port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
      if (!port) begin
         bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.cpu_req = 1'b1;
      end else begin
         bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wdata; bus.dbg_req = 1'b1;
      end
   endtask

   task automatic drop(input logic port);
      if (!port) bus.cpu_req = 1'b0;
      else       bus.dbg_req = 1'b0;
   endtask

   task automatic wait_gnts(input int rem, input string name);
      int n = 0;
      while (gnt_q.size() > rem && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) timeout(name);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((gnt_q.size() != 0 || done_q.size() != 0 || bus.busy) && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) timeout(name);
   endtask

   task automatic access(input logic port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rd, input string name);
      push(port, we, addr, wdata, rd, cyc + 1);
      set_req(port, we, addr, wdata);
      wait_gnts(0, name);
      drop(port);
      wait_idle(name);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      shadow[0] = '0;
      shadow[1] = '0;
      tick();
   endtask

   // Abort an in-flight debug read with reset, either in GRANT or in the first WAIT cycle.
   task automatic abort(input bit in_grant);
      if (in_grant) begin
         set_req(1'b1, 1'b0, 32'h24, 32'h0);
         tick();
         check("abort_pre_mem_en", 32'(bus.mem_en), 32'd1);
      end else begin
         push(1'b1, 1'b0, 32'h24, 32'h0, 32'h5500_0024, cyc + 1);
         set_req(1'b1, 1'b0, 32'h24, 32'h0);
         tick();
         tick();
         check("abort_pre_owner", 32'(bus.owner), 32'd1);
      end
      drop(1'b1);
      reset = 1'b0;
      #1;
      check("abort_mem_en", 32'(bus.mem_en), 32'd0);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_owner", 32'(bus.owner), 32'd0);
      check("abort_gnt_done", {28'b0, bus.cpu_gnt, bus.dbg_gnt, bus.cpu_done, bus.dbg_done}, 32'd0);
      check("abort_dbg_rdata", bus.dbg_rdata, 32'd0);
      if (!in_grant) void'(done_q.pop_back());
      shadow[0] = '0;
      shadow[1] = '0;
      tick();
      tick();
      reset = 1'b1;
      tick();
   endtask

   logic [9:0] pattern;

   initial begin
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
      shadow[0] = '0; shadow[1] = '0;
      gnt_cyc[0] = 0; gnt_cyc[1] = 0;

      // Reset before any clock edge: outputs must clear asynchronously.
      #1 reset = 1'b0;
      #1;
      check("rst_ctrl", {24'b0, bus.cpu_gnt, bus.dbg_gnt, bus.cpu_done, bus.dbg_done,
                         bus.mem_en, bus.mem_we, bus.busy, bus.owner}, 32'd0);
      check("rst_mem_addr", bus.mem_addr, 32'd0);
      check("rst_mem_wdata", bus.mem_wdata, 32'd0);
      check("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
      check("rst_dbg_rdata", bus.dbg_rdata, 32'd0);
      tick();
      tick();
      reset = 1'b1;
      tick();

      // CPU read of 0x10 returns 0xDEADBEEF.
      access(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, "cpu_read");

      // Simultaneous requests after reset: CPU first, debug one access later.
      do_reset();
      push(1'b0, 1'b0, 32'h14, 32'h0, 32'h5500_0014, cyc + 1);
      push(1'b1, 1'b0, 32'h18, 32'h0, 32'h5500_0018, cyc + 1 + (LAT + 3));
      set_req(1'b0, 1'b0, 32'h14, 32'h0);
      set_req(1'b1, 1'b0, 32'h18, 32'h0);
      wait_gnts(1, "tie_cpu");
      drop(1'b0);
      wait_gnts(0, "tie_dbg");
      drop(1'b1);
      wait_idle("tie");

      // Debug write; dbg_rdata must keep the previous read value.
      access(1'b1, 1'b1, 32'h20, 32'h0000_1234, 32'h0, "dbg_write");

      // Both requests held: bit i set means grant i goes to debug.
      do_reset();
`ifdef MEM_ARB_RR_EN
      pattern = 10'h2AA;
`else
      pattern = 10'h100;
`endif
      for (int i = 0; i < 10; i++) begin
         push(pattern[i], 1'b0, pattern[i] ? 32'h20 : 32'h10, 32'h0,
              pattern[i] ? 32'h0000_1234 : 32'hDEAD_BEEF, cyc + 1 + i * (LAT + 3));
      end
      set_req(1'b0, 1'b0, 32'h10, 32'h0);
      set_req(1'b1, 1'b0, 32'h20, 32'h0);
      wait_gnts(0, "held");
      drop(1'b0);
      drop(1'b1);
      wait_idle("held");

      abort(1'b1);
      abort(1'b0);
      access(1'b0, 1'b0, 32'h14, 32'h0, 32'h5500_0014, "post_reset_read");
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single-port synchronous data/instruction memory of the multi-cycle ARM computer. It shares the memory between the CPU datapath (fetch and LDR/STR accesses) and a debug/loader port. Each access runs as one fixed sequence: arbitrate, issue, wait for memory latency, respond. The CPU controller stalls its FSM on `cpu_req && !cpu_done`.

## Interface

Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `MEM_LAT`, 1: memory read latency in cycles, from the `mem_en` cycle to `mem_rdata` valid; legal range 1..7.
- `MAX_WAIT`, 8: fixed-priority mode only; number of arbitrations the debug port may lose before it is forced to win. Legal range 1..15.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_req`, `dbg_req`  in  1  access request; held high until the matching `*_gnt`.
- `cpu_we`, `dbg_we`  in  1  1 = write, 0 = read.
- `cpu_addr`, `dbg_addr`  in  ADDR_W  byte address.
- `cpu_wdata`, `dbg_wdata`  in  DATA_W  write data.
- `cpu_gnt`, `dbg_gnt`  out  1  one-cycle pulse: request accepted and latched.
- `cpu_done`, `dbg_done`  out  1  one-cycle pulse: access complete.
- `cpu_rdata`, `dbg_rdata`  out  DATA_W  read data. Valid from the `*_done` cycle, held until that port's next read completes.
- `mem_en`, `mem_we`  out  1  memory strobe and write enable.
- `mem_addr`, `mem_wdata`  out  ADDR_W / DATA_W  registered memory address and write data.
- `mem_rdata`  in  DATA_W  memory read data.
- `busy`  out  1  high in every state except IDLE.
- `owner`  out  1  current or last owner; 0 = CPU, 1 = debug.

## Operation

FSM states:
- IDLE
- GRANT: one cycle.
- WAIT: MEM_LAT cycles, counted by a 3-bit down-counter.
- RESP: one cycle.

Transitions:
- IDLE → GRANT when either request is high. Otherwise stay in IDLE.
- GRANT → WAIT always.
- WAIT → RESP when the counter reaches 0.
- RESP → IDLE always.

Arbitration (evaluated in IDLE only):
- On the IDLE→GRANT edge, the winner's `we`/`addr`/`wdata` are latched into `mem_we`/`mem_addr`/`mem_wdata` registers, and `owner` is updated.
- The requester may change its inputs after its `gnt`.
- Fixed priority: CPU wins ties. A 4-bit starvation counter increments whenever the debug port loses an arbitration with `dbg_req` high. When the counter equals MAX_WAIT, the debug port wins the next arbitration. The counter clears on any debug grant.

GRANT cycle:
- `mem_en` = 1 and `mem_we` = the latched `we`.
- The winner's `*_gnt` = 1.

WAIT:
- The `mem_rdata` value present in the last WAIT cycle is captured into the owner's `*_rdata` register, for reads only.
- Writes never modify `*_rdata`.

RESP:
- The owner's `*_done` = 1. This is the same for reads and writes.

Request held after `done`:
- A request still high after `done` re-arbitrates from IDLE like a new request.

Reset:
- Asserting `reset` in any state forces IDLE immediately.
- All outputs clear to 0 immediately. In particular `mem_en` drops asynchronously.
- The starvation counter clears, and the round-robin pointer resets to "last = debug".
- An in-flight access is discarded with no `done`; the requester re-issues it.

## Timing

- Reset values: all `*_gnt`, `*_done`, `mem_en`, `mem_we`, `busy`, `owner` = 0; `mem_addr`, `mem_wdata`, `cpu_rdata`, `dbg_rdata` = 0.
- Cycle budget, request seen in IDLE at cycle 0:
  - cycle 1: `gnt` and `mem_en`.
  - cycles 2..MEM_LAT+1: WAIT.
  - cycle MEM_LAT+2: `done`.
  - Back to IDLE at MEM_LAT+3.
- Back-to-back throughput: one access per MEM_LAT+3 cycles.
- `mem_en` is high for exactly one cycle per access and never while the FSM is in IDLE, WAIT or RESP.
- `busy` is high from GRANT through RESP inclusive.
- Requests arriving while the FSM is outside IDLE are ignored until IDLE.

## Configuration

- Macro `MEM_ARB_RR_EN`.
- Defined: round-robin arbitration. On a tie, the port that was not the last winner wins. The starvation counter and `MAX_WAIT` are unused.
- Undefined: fixed CPU priority with the `MAX_WAIT` starvation escape described above.

## Test plan

- CPU read of 0x10, MEM_LAT=1, memory returns 0xDEADBEEF → `cpu_gnt` and `mem_en` in cycle 1 with `mem_addr`=0x10; `cpu_done` in cycle 3; `cpu_rdata`=0xDEADBEEF.
- Both requests rise together in fixed mode → CPU granted at cycle 1, `dbg_gnt` at cycle 5; `owner` goes 0 then 1.
- Fixed mode, MAX_WAIT=8, both requests held continuously → CPU wins 8 arbitrations, debug wins the 9th, then CPU wins the 10th.
- `MEM_ARB_RR_EN` defined, both requests held → grants alternate CPU, DBG, CPU, DBG.
- `reset` asserted low during WAIT → `mem_en`/`busy`/`owner` are 0 immediately and no `done` is issued. A new CPU request after release completes normally in MEM_LAT+2 cycles.
- Debug write to 0x20 with data 0x1234, MEM_LAT=3 → `mem_en`=`mem_we`=1 for one cycle; `dbg_done` at cycle 5; `dbg_rdata` unchanged.
